// File: rtl/neq_pkg.sv
// Shared constants and helper functions for the neq_stream lane comparator.
// The counter helpers work on a fixed 64-bit carrier so one definition serves every parameterisation.
package neq_pkg;

    localparam int POPW = 64;

    function automatic int maxw(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [POPW-1:0] popcount(input logic [POPW-1:0] v);
        logic [POPW-1:0] n;
        n = '0;
        for (int i = 0; i < POPW; i++) begin
            n = n + {{(POPW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Counters wider than the carrier saturate at the carrier limit instead of 2^cntw-1.
    function automatic logic [POPW-1:0] sat_add(input logic [POPW-1:0] acc,
                                                input logic [POPW-1:0] inc,
                                                input int cntw);
        logic [POPW:0]   sum;
        logic [POPW-1:0] lim;
        if (cntw >= POPW) begin
            lim = '1;
        end else begin
            lim = (64'd1 << cntw) - 64'd1;
        end
        sum = {1'b0, acc} + {1'b0, inc};
        if (sum > {1'b0, lim}) begin
            return lim;
        end
        return sum[POPW-1:0];
    endfunction

endpackage

// File: rtl/neq_lane.sv
// One combinational compare lane: extend both operands to a common width, test for
// inequality and place the result bit at bit 0 of an otherwise-zero field.
module neq_lane
    import neq_pkg::*;
#(
    parameter int AW = 9,
    parameter int BW = 6,
    parameter int OW = 16
) (
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic          sgn,
    output logic [OW-1:0] res,
    output logic          mis
);

    localparam int W = maxw(AW, BW);

    logic [W-1:0] ea;
    logic [W-1:0] eb;

    // A size cast of a signed value sign-extends; of an unsigned value it zero-extends.
    always_comb begin
        if (sgn) begin
            ea = W'($signed(a));
            eb = W'($signed(b));
        end else begin
            ea = W'(a);
            eb = W'(b);
        end
    end

    assign mis = (ea != eb);

    always_comb begin
        res    = '0;
        res[0] = mis;
    end

endmodule

// File: rtl/neq_stream.sv
// Two-stage valid/ready stream of NLANES independent inequality compares with a
// saturating count of mismatching lanes in delivered beats.
module neq_stream
    import neq_pkg::*;
#(
    parameter int AW     = 9,
    parameter int BW     = 6,
    parameter int NLANES = 4,
    parameter int OW     = 16,
    parameter int CNTW   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NLANES*AW-1:0]   in_a,
    input  logic [NLANES*BW-1:0]   in_b,
    input  logic                   in_signed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NLANES*OW-1:0]   out_res,
    output logic                   out_any,
    input  logic                   clr_count,
    output logic [CNTW-1:0]        mismatch_count
);

    logic                  s1_valid;
    logic [NLANES*AW-1:0]  s1_a;
    logic [NLANES*BW-1:0]  s1_b;
    logic                  s1_signed;

    logic                  s2_valid;
    logic [NLANES*OW-1:0]  s2_res;
    logic                  s2_any;
    logic [NLANES-1:0]     s2_mis;

    logic [NLANES*OW-1:0]  lane_res;
    logic [NLANES-1:0]     lane_mis;

    logic                  in_fire;
    logic                  out_fire;
    logic                  s2_load;
    logic [CNTW-1:0]       count_base;
    logic [CNTW-1:0]       count_next;

    // S1 can only refill while occupied if S2 is able to take its beat this cycle.
    assign in_ready = !s1_valid || !s2_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid && out_ready;
    assign s2_load  = s1_valid && (!s2_valid || out_ready);

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        neq_lane #(
            .AW (AW),
            .BW (BW),
            .OW (OW)
        ) u_lane (
            .a   (s1_a[i*AW +: AW]),
            .b   (s1_b[i*BW +: BW]),
            .sgn (s1_signed),
            .res (lane_res[i*OW +: OW]),
            .mis (lane_mis[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_signed <= 1'b0;
        end else if (in_fire) begin
            s1_valid  <= 1'b1;
            s1_a      <= in_a;
            s1_b      <= in_b;
            s1_signed <= in_signed;
        end else if (s2_load) begin
            s1_valid  <= 1'b0;
        end
    end

    // S2 holds its contents untouched while stalled so the output beat stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_any   <= 1'b0;
            s2_mis   <= '0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            s2_res   <= lane_res;
            s2_any   <= |lane_mis;
            s2_mis   <= lane_mis;
        end else if (out_fire) begin
            s2_valid <= 1'b0;
        end
    end

    // A clear coinciding with a delivery restarts the count from that beat's mismatches.
    always_comb begin
        count_base = clr_count ? '0 : mismatch_count;
        count_next = CNTW'(sat_add(POPW'(count_base), popcount(POPW'(s2_mis)), CNTW));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch_count <= '0;
        end else if (out_fire) begin
            mismatch_count <= count_next;
        end else if (clr_count) begin
            mismatch_count <= '0;
        end
    end

    assign out_valid = s2_valid;
    assign out_res   = s2_res;
    assign out_any   = s2_any;

endmodule
